// File: rtl/mcfsm_pkg.sv
// mcfsm_pkg: shared definitions for the multi-cycle RV32I control FSM.
//   - state_t: FSM state encoding (also visible on state_o for debug)
//   - RV32I major opcode constants
//   - datapath mux/ALU encodings shared with the multi-cycle datapath
//   - ctrl_t: bundle of all datapath strobes produced by the FSM
package mcfsm_pkg;

  typedef enum logic [3:0] {
    ST_IF   = 4'd0,
    ST_ID   = 4'd1,
    ST_EX   = 4'd2,
    ST_MEM  = 4'd3,
    ST_WB   = 4'd4,
    ST_HALT = 4'd5
  } state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IARITH = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic       ALU_A_PC      = 1'b0;
  localparam logic       ALU_A_RS1     = 1'b1;
  localparam logic [1:0] ALU_B_RS2     = 2'b00;
  localparam logic [1:0] ALU_B_FOUR    = 2'b01;
  localparam logic [1:0] ALU_B_IMM     = 2'b10;
  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_BR     = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;
  localparam logic [1:0] WB_ALUOUT     = 2'b00;
  localparam logic [1:0] WB_MDR        = 2'b01;
  localparam logic [1:0] WB_PC4        = 2'b10;
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;

  // a7 value that requests program exit through ECALL
  localparam logic [31:0] ECALL_EXIT = 32'd10;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  // Opcodes that proceed from ID into EX (ECALL is handled separately in ID)
  function automatic logic is_exec_op(input logic [6:0] op);
    case (op)
      OP_RTYPE, OP_IARITH, OP_LOAD, OP_STORE,
      OP_BRANCH, OP_JAL, OP_JALR: is_exec_op = 1'b1;
      default:                    is_exec_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mcfsm_wait_counter.sv
// mcfsm_wait_counter: memory-latency wait counter for the control FSM.
//   clk   - clock
//   reset - asynchronous active-low reset (count -> 0)
//   clr   - synchronous clear, has priority over en
//   en    - advance the count by one
//   done  - count has reached MEM_LAT-1 (always true when MEM_LAT==1)
module mcfsm_wait_counter
#(
  parameter int MEM_LAT = 4,
  parameter int CNT_W   = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic done
);

  logic [CNT_W-1:0] cnt_r;

  // Count register: clear wins so the count never passes MEM_LAT-1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign done = (cnt_r == CNT_W'(MEM_LAT - 1));

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: multi-cycle RV32I control FSM (IF/ID/EX/MEM/WB/HALT).
// Memory accesses in IF and MEM last MEM_LAT cycles, timed by mcfsm_wait_counter.
// Strobes are decoded combinationally from state/opcode/wait counter and are
// forced to 0 while reset is low.
// Optional feature macro: MCFSM_ECALL_HALT_EN -- ECALL with x17_val==10 enters
// a sticky HALT state; without it ECALL is a NOP and halted stays 0.
// Ports:
//   clk, reset (async active-low), opcode (IR[6:0]), bcond (branch taken, EX),
//   x17_val (a7, read in ID), pc_write, ir_write, i_or_d, mem_read, mem_write,
//   mem_to_reg[1:0], reg_write, alu_src_a, alu_src_b[1:0], alu_op[1:0],
//   pc_source[1:0], halted, state_o[3:0] (debug state).
module multicycle_ctrl_fsm
  import mcfsm_pkg::*;
#(
  parameter int MEM_LAT = 4,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        bcond,
  input  logic [31:0] x17_val,
  output logic        pc_write,
  output logic        ir_write,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_to_reg,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_source,
  output logic        halted,
  output logic [3:0]  state_o
);

  state_t state_r;
  logic   halted_r;
  logic   in_wait_s;
  logic   wait_done_s;
  logic   halt_req_s;
  logic   is_load_s;
  logic   is_store_s;
  logic   is_jump_s;
  ctrl_t  ctrl_s;
  ctrl_t  ctrl_out_s;

  assign in_wait_s  = (state_r == ST_IF) || (state_r == ST_MEM);
  assign is_load_s  = (opcode == OP_LOAD);
  assign is_store_s = (opcode == OP_STORE);
  assign is_jump_s  = (opcode == OP_JAL) || (opcode == OP_JALR);

`ifdef MCFSM_ECALL_HALT_EN
  assign halt_req_s = (x17_val == ECALL_EXIT);
`else
  logic unused_x17_s;
  assign halt_req_s   = 1'b0;
  assign unused_x17_s = ^x17_val;
`endif

  // Clearing on the completing cycle leaves the count at 0 on entry to the next IF/MEM
  mcfsm_wait_counter #(
    .MEM_LAT (MEM_LAT),
    .CNT_W   (CNT_W)
  ) u_wait (
    .clk   (clk),
    .reset (reset),
    .clr   (!in_wait_s || wait_done_s),
    .en    (in_wait_s),
    .done  (wait_done_s)
  );

  // State sequencing and sticky halt flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_IF;
      halted_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IF: begin
          state_r <= wait_done_s ? ST_ID : ST_IF;
        end
        ST_ID: begin
          if (opcode == OP_SYSTEM) begin
            state_r  <= halt_req_s ? ST_HALT : ST_IF;
            halted_r <= halt_req_s;
          end else if (is_exec_op(opcode)) begin
            state_r <= ST_EX;
          end else begin
            state_r <= ST_IF;
          end
        end
        ST_EX: begin
          if (is_load_s || is_store_s) begin
            state_r <= ST_MEM;
          end else if (opcode == OP_BRANCH) begin
            state_r <= ST_IF;
          end else if (is_exec_op(opcode)) begin
            state_r <= ST_WB;
          end else begin
            state_r <= ST_IF;
          end
        end
        ST_MEM: begin
          if (wait_done_s) begin
            state_r <= is_load_s ? ST_WB : ST_IF;
          end else begin
            state_r <= ST_MEM;
          end
        end
        ST_WB: begin
          state_r <= ST_IF;
        end
        ST_HALT: begin
          state_r <= ST_HALT;
        end
        default: begin
          state_r  <= ST_IF;
          halted_r <= 1'b0;
        end
      endcase
    end
  end

  // Strobe decode from current state, opcode and wait-counter completion
  always_comb begin
    ctrl_s = '0;
    case (state_r)
      ST_IF: begin
        ctrl_s.mem_read  = 1'b1;
        ctrl_s.ir_write  = wait_done_s;
        ctrl_s.pc_write  = wait_done_s;
        ctrl_s.alu_src_a = ALU_A_PC;
        ctrl_s.alu_src_b = wait_done_s ? ALU_B_FOUR : ALU_B_RS2;
        ctrl_s.alu_op    = ALU_OP_ADD;
        ctrl_s.pc_source = PC_SRC_ALU;
      end
      ST_ID: begin
        // PC + imm lands in ALUOut as the branch/JAL target
        ctrl_s.alu_src_a = ALU_A_PC;
        ctrl_s.alu_src_b = ALU_B_IMM;
        ctrl_s.alu_op    = ALU_OP_ADD;
      end
      ST_EX: begin
        case (opcode)
          OP_RTYPE: begin
            ctrl_s.alu_src_a = ALU_A_RS1;
            ctrl_s.alu_src_b = ALU_B_RS2;
            ctrl_s.alu_op    = ALU_OP_FUNCT;
          end
          OP_IARITH: begin
            ctrl_s.alu_src_a = ALU_A_RS1;
            ctrl_s.alu_src_b = ALU_B_IMM;
            ctrl_s.alu_op    = ALU_OP_FUNCT;
          end
          OP_LOAD, OP_STORE: begin
            ctrl_s.alu_src_a = ALU_A_RS1;
            ctrl_s.alu_src_b = ALU_B_IMM;
            ctrl_s.alu_op    = ALU_OP_ADD;
          end
          OP_BRANCH: begin
            ctrl_s.alu_src_a = ALU_A_RS1;
            ctrl_s.alu_src_b = ALU_B_RS2;
            ctrl_s.alu_op    = ALU_OP_BR;
            ctrl_s.pc_source = PC_SRC_ALUOUT;
            ctrl_s.pc_write  = bcond;
          end
          OP_JAL: begin
            ctrl_s.pc_write  = 1'b1;
            ctrl_s.pc_source = PC_SRC_ALUOUT;
          end
          OP_JALR: begin
            ctrl_s.alu_src_a = ALU_A_RS1;
            ctrl_s.alu_src_b = ALU_B_IMM;
            ctrl_s.alu_op    = ALU_OP_ADD;
            ctrl_s.pc_write  = 1'b1;
            ctrl_s.pc_source = PC_SRC_ALU;
          end
          default: begin
            ctrl_s = '0;
          end
        endcase
      end
      ST_MEM: begin
        ctrl_s.i_or_d    = 1'b1;
        ctrl_s.mem_read  = is_load_s;
        ctrl_s.mem_write = is_store_s;
        // ir_write doubles as the MDR capture strobe for loads
        ctrl_s.ir_write  = is_load_s && wait_done_s;
      end
      ST_WB: begin
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.mem_to_reg = is_load_s ? WB_MDR : (is_jump_s ? WB_PC4 : WB_ALUOUT);
      end
      ST_HALT: begin
        ctrl_s = '0;
      end
      default: begin
        ctrl_s = '0;
      end
    endcase
  end

  // Strobes are held inactive for the whole time reset is low
  assign ctrl_out_s = reset ? ctrl_s : '0;

  assign pc_write   = ctrl_out_s.pc_write;
  assign ir_write   = ctrl_out_s.ir_write;
  assign i_or_d     = ctrl_out_s.i_or_d;
  assign mem_read   = ctrl_out_s.mem_read;
  assign mem_write  = ctrl_out_s.mem_write;
  assign mem_to_reg = ctrl_out_s.mem_to_reg;
  assign reg_write  = ctrl_out_s.reg_write;
  assign alu_src_a  = ctrl_out_s.alu_src_a;
  assign alu_src_b  = ctrl_out_s.alu_src_b;
  assign alu_op     = ctrl_out_s.alu_op;
  assign pc_source  = ctrl_out_s.pc_source;
  assign halted     = halted_r;
  assign state_o    = state_r;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: scoreboard bench for multicycle_ctrl_fsm.
// Two instances: MEM_LAT=4 (index 0) and MEM_LAT=1 (index 1). For every
// instruction issued, a reference model expands the instruction into its
// expected per-cycle output records and queues them; a monitor pops one
// record per cycle and compares it with the DUT outputs.
module tb_multicycle_ctrl_fsm;
  import mcfsm_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic       halted;
    logic       pc_write;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } rec_t;

  typedef enum int {K_R, K_I, K_LD, K_ST, K_BR, K_JAL, K_JALR, K_ECALL, K_BAD} kind_t;

  localparam int N_DUT = 2;
`ifdef MCFSM_ECALL_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode_a [N_DUT];
  logic        bcond_a  [N_DUT];
  logic [31:0] x17_a    [N_DUT];
  rec_t        obs      [N_DUT];
  rec_t        exp_q0 [$];
  rec_t        exp_q1 [$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [6:0]  op_pool [10];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 4 : 1;
    logic       pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write;
    logic       alu_src_a, halted;
    logic [1:0] mem_to_reg, alu_src_b, alu_op, pc_source;
    logic [3:0] state_o;

    multicycle_ctrl_fsm #(.MEM_LAT(LAT), .CNT_W(4)) u_dut (
      .clk        (clk),
      .reset      (rst_n),
      .opcode     (opcode_a[g]),
      .bcond      (bcond_a[g]),
      .x17_val    (x17_a[g]),
      .pc_write   (pc_write),
      .ir_write   (ir_write),
      .i_or_d     (i_or_d),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_to_reg (mem_to_reg),
      .reg_write  (reg_write),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_op     (alu_op),
      .pc_source  (pc_source),
      .halted     (halted),
      .state_o    (state_o)
    );

    assign obs[g] = {state_o, halted, pc_write, ir_write, i_or_d, mem_read, mem_write,
                     mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
  end

  function automatic kind_t classify(input logic [6:0] op);
    case (op)
      7'b0110011: return K_R;
      7'b0010011: return K_I;
      7'b0000011: return K_LD;
      7'b0100011: return K_ST;
      7'b1100011: return K_BR;
      7'b1101111: return K_JAL;
      7'b1100111: return K_JALR;
      7'b1110011: return K_ECALL;
      default:    return K_BAD;
    endcase
  endfunction

  function automatic rec_t blank(input state_t s);
    rec_t r;
    r = '0;
    r.st = s;
    return r;
  endfunction

  task automatic chk_rec(input string name, input int g, input rec_t got, input rec_t exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s dut%0d @%0t: got %h expected %h", name, g, $time, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    n_vec = n_vec + 1;
    if (got != exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference model: expand one instruction into its cycle-by-cycle outputs
  task automatic build(input int g, input logic [6:0] op, input logic bc,
                       input logic [31:0] x17, output int n);
    int    lat;
    kind_t k;
    rec_t  r;
    rec_t  seq [$];
    lat = (g == 0) ? 4 : 1;
    k = classify(op);
    for (int i = 0; i < lat; i++) begin
      r = blank(ST_IF);
      r.mem_read = 1'b1;
      if (i == lat - 1) begin
        r.ir_write = 1'b1; r.pc_write = 1'b1; r.alu_src_b = 2'b01;
      end
      seq.push_back(r);
    end
    r = blank(ST_ID);
    r.alu_src_b = 2'b10;
    seq.push_back(r);
    if (k == K_ECALL && HALT_EN && x17 == 32'd10) begin
      for (int i = 0; i < 20; i++) begin
        r = blank(ST_HALT);
        r.halted = 1'b1;
        seq.push_back(r);
      end
    end else if (k != K_ECALL && k != K_BAD) begin
      r = blank(ST_EX);
      case (k)
        K_R:        begin r.alu_src_a = 1'b1; r.alu_src_b = 2'b00; r.alu_op = 2'b10; end
        K_I:        begin r.alu_src_a = 1'b1; r.alu_src_b = 2'b10; r.alu_op = 2'b10; end
        K_LD, K_ST: begin r.alu_src_a = 1'b1; r.alu_src_b = 2'b10; end
        K_BR: begin
          r.alu_src_a = 1'b1; r.alu_op = 2'b01; r.pc_source = 2'b01; r.pc_write = bc;
        end
        K_JAL:  begin r.pc_write = 1'b1; r.pc_source = 2'b01; end
        K_JALR: begin r.alu_src_a = 1'b1; r.alu_src_b = 2'b10; r.pc_write = 1'b1; end
        default: r = blank(ST_EX);
      endcase
      seq.push_back(r);
      if (k == K_LD || k == K_ST) begin
        for (int i = 0; i < lat; i++) begin
          r = blank(ST_MEM);
          r.i_or_d    = 1'b1;
          r.mem_read  = (k == K_LD);
          r.mem_write = (k == K_ST);
          r.ir_write  = (k == K_LD) && (i == lat - 1);
          seq.push_back(r);
        end
      end
      if (k != K_BR && k != K_ST) begin
        r = blank(ST_WB);
        r.reg_write  = 1'b1;
        r.mem_to_reg = (k == K_LD) ? 2'b01 : ((k == K_JAL || k == K_JALR) ? 2'b10 : 2'b00);
        seq.push_back(r);
      end
    end
    foreach (seq[i]) begin
      if (g == 0) exp_q0.push_back(seq[i]);
      else        exp_q1.push_back(seq[i]);
    end
    n = seq.size();
  endtask

  task automatic issue(input int g, input logic [6:0] op, input logic bc, input logic [31:0] x17);
    int n;
    opcode_a[g] = op;
    bcond_a[g]  = bc;
    x17_a[g]    = x17;
    build(g, op, bc, x17, n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue_random(input int g, input int count);
    logic [31:0] x;
    for (int i = 0; i < count; i++) begin
      x = $urandom;
      if (x == 32'd10) x = 32'd11;
      issue(g, op_pool[$urandom_range(0, 9)], 1'($urandom_range(0, 1)), x);
    end
  endtask

  // Hold reset low, discard pending expectations, check the reset outputs
  task automatic reset_check(input int cycles);
    rec_t rst_exp;
    rst_exp = blank(ST_IF);
    rst_n = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      for (int g = 0; g < N_DUT; g++) chk_rec("reset_outputs", g, obs[g], rst_exp);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: one expected record per DUT per cycle, sampled mid-cycle
  initial begin
    rec_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (exp_q0.size() > 0) begin
          e = exp_q0.pop_front();
          chk_rec("cycle", 0, obs[0], e);
        end
        if (exp_q1.size() > 0) begin
          e = exp_q1.pop_front();
          chk_rec("cycle", 1, obs[1], e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int n_dummy;
    op_pool[0] = 7'b0110011; op_pool[1] = 7'b0010011; op_pool[2] = 7'b0000011;
    op_pool[3] = 7'b0100011; op_pool[4] = 7'b1100011; op_pool[5] = 7'b1101111;
    op_pool[6] = 7'b1100111; op_pool[7] = 7'b1110011; op_pool[8] = 7'b0110111;
    op_pool[9] = 7'b0000000;
    for (int g = 0; g < N_DUT; g++) begin
      opcode_a[g] = 7'b0110011;
      bcond_a[g]  = 1'b1;
      x17_a[g]    = 32'd0;
    end

    reset_check(3);

    // MEM_LAT=4 instance: directed ADD, LW, BEQ taken / not taken
    issue(0, 7'b0110011, 1'b0, 32'd0);
    issue(0, 7'b0000011, 1'b0, 32'd0);
    issue(0, 7'b1100011, 1'b1, 32'd0);
    issue(0, 7'b1100011, 1'b0, 32'd0);
    issue(0, 7'b1110011, 1'b0, 32'd5);
    issue_random(0, 30);

    // Abort a load in the middle of its memory phase
    opcode_a[0] = 7'b0000011;
    build(0, 7'b0000011, 1'b0, 32'd0, n_dummy);
    repeat (7) @(posedge clk);
    #1;
    reset_check(2);
    issue(0, 7'b0010011, 1'b0, 32'd0);

    if (HALT_EN) begin
      issue(0, 7'b1110011, 1'b0, 32'd10);
      reset_check(2);
      issue(0, 7'b0110011, 1'b0, 32'd0);
    end
    issue_random(0, 5);

    // MEM_LAT=1 instance from a clean reset: SW, JAL, then random
    reset_check(2);
    issue(1, 7'b0100011, 1'b0, 32'd0);
    issue(1, 7'b1101111, 1'b0, 32'd0);
    issue(1, 7'b1100111, 1'b0, 32'd0);
    issue(1, 7'b0000011, 1'b0, 32'd0);
    issue_random(1, 30);

    repeat (2) @(posedge clk);
    #1;
    chk_int("q0_drain", exp_q0.size(), 0);
    chk_int("q1_drain", exp_q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
